alloc_request_arbiter: RTL and testbench
========================================

// Module: alloc_request_arbiter
// PURPOSE
//  Upstream stage of Memory_Management_Unit allocation port. Collects alloc requests from NUM_FPUS FSM cores.
//  Round-robin picks one, issues it as a single-cycle MMU alloc_request_valid, waits for alloc_grant.
//  Returns address+ack, or fail on timeout, to the winner only. One allocation in flight at a time.
// PARAMETERS
//  NUM_FPUS        16  number of requesting FPUs
//  FPU_ID_WIDTH     4  width of FPU index (>= clog2(NUM_FPUS))
//  GRANT_TIMEOUT    4  WAIT cycles without alloc_grant before reporting fail (>= 1)
// PORTS
//  clk                     in   1               system clock, all logic on rising edge
//  reset_n                 in   1               asynchronous, active-low reset
//  fpu_alloc_req           in   NUM_FPUS        per-FPU request level, held until ack/fail
//  fpu_alloc_size          in   NUM_FPUS*16     per-FPU size in bytes, slice [16*i+15:16*i]
//  fpu_alloc_ack           out  NUM_FPUS        one-cycle success pulse to winner
//  fpu_alloc_fail          out  NUM_FPUS        one-cycle failure pulse to winner
//  fpu_alloc_addr          out  32              shared address, valid with ack; 0 with fail
//  mmu_alloc_request_from  out  FPU_ID_WIDTH    to MMU alloc_request_from
//  mmu_alloc_size          out  16              to MMU alloc_size
//  mmu_alloc_request_valid out  1               to MMU alloc_request_valid
//  mmu_alloc_address       in   32              from MMU alloc_address
//  mmu_alloc_grant         in   1               from MMU alloc_grant (registered, 1 cycle after valid)
//  debug_state             out  2               current FSM state encoding
//  debug_fail_count        out  16              saturating count of fail responses
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; every output 0; last_winner=NUM_FPUS-1 (FPU 0 first priority).
//  Reset mid-transaction drops it silently; no ack/fail is emitted.
//  FSM: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
//  - IDLE
//    - If any fpu_alloc_req bit is set: winner = first set bit scanning last_winner+1 upward, wrapping mod NUM_FPUS.
//    - Latch winner id and size, then go to ISSUE.
//    - Latched size==0: skip MMU, go to RESP with fail.
//  - ISSUE
//    - mmu_alloc_request_valid=1 for exactly this cycle, with the latched id/size on mmu_alloc_request_from/mmu_alloc_size.
//    - Clear timer; go to WAIT.
//  - WAIT
//    - mmu_alloc_grant=1: latch mmu_alloc_address; go to RESP with success.
//    - Otherwise timer++. Timer reaching GRANT_TIMEOUT: go to RESP with fail.
//  - RESP
//    - Success: fpu_alloc_ack[winner]=1 and fpu_alloc_addr=latched address.
//    - Fail: fpu_alloc_fail[winner]=1, fpu_alloc_addr=0, debug_fail_count++ (saturates at 16'hFFFF).
//    - Set last_winner=winner; go to IDLE.
//  - Ack/fail/addr are registered, high for one cycle only, and 0 in all other states.
//  - mmu_alloc_request_from/mmu_alloc_size hold their last value outside ISSUE; mmu_alloc_request_valid is 0 outside ISSUE.
//  Timing: req sampled in IDLE at cycle 0 -> valid cycle 1 -> grant seen cycle 2 -> ack cycle 3. Minimum 4 cycles per allocation.
//  Request inputs are sampled only in IDLE; changes in ISSUE/WAIT/RESP are ignored.
//  Winner dropping req mid-transaction: transaction still completes and the pulse is still emitted.
//  A req still high in the IDLE after RESP counts as a new request; requesters drop req on the cycle after ack/fail.
//  mmu_alloc_grant outside WAIT is ignored; no state change.
//  Width rules:
//  - winner index is computed modulo NUM_FPUS.
//  - timer is clog2(GRANT_TIMEOUT+1) bits.
//  - NUM_FPUS not a power of two: indices >= NUM_FPUS are never selected.
// TESTING
//  T1: FPU3 req size=100; MMU grants addr 0x10000300 on cycle 2 -> valid cycle 1 with from=3/size=100; ack[3] and addr=0x10000300 cycle 3.
//  T2: FPUs 0,5,9 req together and stay high; MMU always grants -> served order 0,5,9, then 0 again; one ack each per 4 cycles.
//  T3: FPU7 req size=512; MMU never grants -> fail[7] after 4 WAIT cycles, addr=0, debug_fail_count=1, no ack.
//  T4: FPU2 req size=0 -> mmu_alloc_request_valid stays 0; fail[2] pulses; fail count increments.
//  T5: reset_n low during WAIT -> all outputs 0 immediately; after release FPU0 has priority over FPU15 with both requesting.
//  T6: FPUs 1 and 2 hold req continuously -> acks alternate 1,2,1,2; no FPU starves; stray grant in IDLE produces no pulse.

Source files
------------

// File: rtl/alloc_request_arbiter.sv
// Round-robin front end for the MMU allocation port: picks one FPU request,
// issues it to the MMU, and returns ack+address or fail to that FPU only.
module alloc_request_arbiter #(
    parameter int NUM_FPUS      = 16,
    parameter int FPU_ID_WIDTH  = 4,
    parameter int GRANT_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_FPUS-1:0]     fpu_alloc_req,
    input  logic [NUM_FPUS*16-1:0]  fpu_alloc_size,
    output logic [NUM_FPUS-1:0]     fpu_alloc_ack,
    output logic [NUM_FPUS-1:0]     fpu_alloc_fail,
    output logic [31:0]             fpu_alloc_addr,
    output logic [FPU_ID_WIDTH-1:0] mmu_alloc_request_from,
    output logic [15:0]             mmu_alloc_size,
    output logic                    mmu_alloc_request_valid,
    input  logic [31:0]             mmu_alloc_address,
    input  logic                    mmu_alloc_grant,
    output logic [1:0]              debug_state,
    output logic [15:0]             debug_fail_count
);
    localparam int TIMER_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [FPU_ID_WIDTH-1:0] last_winner, winner, pick_id, resp_id;
    logic [15:0]             pick_size;
    logic                    pick_found, hi_found;
    int                      hi_idx, lo_idx;
    logic [TIMER_W-1:0]      timer;
    logic                    go_ack, go_fail;
    logic [NUM_FPUS-1:0]     resp_onehot;

    // Lowest requester above last_winner wins; if none, wrap to the lowest overall.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hi_found   = 1'b0;
        hi_idx     = 0;
        lo_idx     = 0;
        pick_found = 1'b0;
        for (int i = NUM_FPUS - 1; i >= 0; i--) begin
            if (fpu_alloc_req[i]) begin
                pick_found = 1'b1;
                lo_idx     = i;
                if (i > int'(last_winner)) begin
                    hi_found = 1'b1;
                    hi_idx   = i;
                end
            end
        end
        pick_id   = FPU_ID_WIDTH'(hi_found ? hi_idx : lo_idx);
        pick_size = '0;
        for (int i = 0; i < NUM_FPUS; i++) begin
            if (int'(pick_id) == i) pick_size = fpu_alloc_size[16*i +: 16];
        end
    end

    always_comb begin
        state_next = state;
        go_ack     = 1'b0;
        go_fail    = 1'b0;
        resp_id    = winner;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    resp_id = pick_id;
                    if (pick_size == 16'd0) begin
                        go_fail    = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // Grant wins over a timeout landing on the same cycle.
                if (mmu_alloc_grant) begin
                    go_ack     = 1'b1;
                    state_next = RESP;
                end else if (timer == TIMER_W'(GRANT_TIMEOUT - 1)) begin
                    go_fail    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        for (int i = 0; i < NUM_FPUS; i++) begin
            resp_onehot[i] = (int'(resp_id) == i);
        end
    end

    // NOTE: asynchronous active-low reset; every register, outputs included, clears to 0
    // except last_winner, which starts at the top so FPU 0 has first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            last_winner            <= FPU_ID_WIDTH'(NUM_FPUS - 1);
            winner                 <= '0;
            timer                  <= '0;
            mmu_alloc_request_from <= '0;
            mmu_alloc_size         <= '0;
            fpu_alloc_ack          <= '0;
            fpu_alloc_fail         <= '0;
            fpu_alloc_addr         <= '0;
            debug_fail_count       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state          <= state_next;
            fpu_alloc_ack  <= go_ack  ? resp_onehot : '0;
            fpu_alloc_fail <= go_fail ? resp_onehot : '0;
            fpu_alloc_addr <= go_ack  ? mmu_alloc_address : '0;
            if (state == IDLE && pick_found) begin
                winner <= pick_id;
                if (pick_size != 16'd0) begin
                    mmu_alloc_request_from <= pick_id;
                    mmu_alloc_size         <= pick_size;
                end
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TIMER_W'(1);
            end
            if (state == RESP) last_winner <= winner;
            if (go_fail && debug_fail_count != 16'hFFFF) begin
                debug_fail_count <= debug_fail_count + 16'd1;
            end
        end
    end

    assign mmu_alloc_request_valid = (state == ISSUE);
    assign debug_state             = state;

endmodule

// File: tb/tb_alloc_request_arbiter.sv
// Directed and randomized bench for alloc_request_arbiter; expectations come from a
// per-transaction timeline model (round-robin pick, fixed cycle offsets per outcome).
module tb_alloc_request_arbiter;
    localparam int N    = 16;
    localparam int IDW  = 4;
    localparam int TO   = 4;
    localparam int NCYC = 2400;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   fpu_alloc_req;
    logic [N*16-1:0] fpu_alloc_size;
    logic [N-1:0]   fpu_alloc_ack, fpu_alloc_fail;
    logic [31:0]    fpu_alloc_addr;
    logic [IDW-1:0] mmu_alloc_request_from;
    logic [15:0]    mmu_alloc_size;
    logic           mmu_alloc_request_valid;
    logic [31:0]    mmu_alloc_address;
    logic           mmu_alloc_grant;
    logic [1:0]     debug_state;
    logic [15:0]    debug_fail_count;

    alloc_request_arbiter #(.NUM_FPUS(N), .FPU_ID_WIDTH(IDW), .GRANT_TIMEOUT(TO)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .fpu_alloc_req          (fpu_alloc_req),
        .fpu_alloc_size         (fpu_alloc_size),
        .fpu_alloc_ack          (fpu_alloc_ack),
        .fpu_alloc_fail         (fpu_alloc_fail),
        .fpu_alloc_addr         (fpu_alloc_addr),
        .mmu_alloc_request_from (mmu_alloc_request_from),
        .mmu_alloc_size         (mmu_alloc_size),
        .mmu_alloc_request_valid(mmu_alloc_request_valid),
        .mmu_alloc_address      (mmu_alloc_address),
        .mmu_alloc_grant        (mmu_alloc_grant),
        .debug_state            (debug_state),
        .debug_fail_count       (debug_fail_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected per-cycle timeline, filled in when a transaction is predicted.
    int          e_state[NCYC], e_ack[NCYC], e_fail[NCYC], e_from[NCYC];
    logic [15:0] e_size[NCYC];
    logic [31:0] e_addr[NCYC], plan_addr[NCYC];
    bit          e_valid[NCYC], plan_grant[NCYC], in_wait[NCYC];
    int          c, next_idle, rel_cycle, last, owner, m_from, m_fcnt;
    logic [15:0] m_size;
    bit          in_reset;

    bit          act[N], hold[N];
    logic [15:0] rsz[N];
    bit          rand_traffic, stray_en, addr_fixed_en;
    int          mmu_mode;
    logic [31:0] addr_fixed;
    int          seen_ack[$], seen_fail[$];
    logic [31:0] seen_addr[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rand_size();
        if ($urandom % 8 == 0) return 16'd0;
        return 16'($urandom_range(65535, 1));
    endfunction

    function automatic int ack_at(input int k);
        return (k < seen_ack.size()) ? seen_ack[k] : -1;
    endfunction

    function automatic int fail_at(input int k);
        return (k < seen_fail.size()) ? seen_fail[k] : -1;
    endfunction

    task automatic clear_from(input int k);
        for (int j = k; j < NCYC; j++) begin
            e_state[j] = 0; e_ack[j] = -1; e_fail[j] = -1; e_from[j] = 0;
            e_size[j] = '0; e_addr[j] = '0; plan_addr[j] = '0;
            e_valid[j] = 1'b0; plan_grant[j] = 1'b0; in_wait[j] = 1'b0;
        end
    endtask

    task automatic clear_seen();
        seen_ack.delete();
        seen_fail.delete();
        seen_addr.delete();
    endtask

    // Predict the whole transaction started by the requests visible in idle cycle c.
    task automatic schedule();
        int          w, d;
        logic [15:0] sz;
        logic [31:0] a;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && act[(last + k) % N]) w = (last + k) % N;
        end
        if (w < 0) begin
            next_idle = c + 1;
            return;
        end
        last  = w;
        owner = w;
        sz    = rsz[w];
        if (sz == 16'd0) begin
            e_state[c+1] = 3; e_fail[c+1] = w; next_idle = c + 2;
            return;
        end
        e_state[c+1] = 1; e_valid[c+1] = 1'b1; e_from[c+1] = w; e_size[c+1] = sz;
        case (mmu_mode)
            0:       d = 0;
            1:       d = TO;
            default: d = int'($urandom_range(TO, 0));
        endcase
        if (d < TO) begin
            for (int j = 0; j <= d; j++) begin
                e_state[c+2+j] = 2; in_wait[c+2+j] = 1'b1;
            end
            a = addr_fixed_en ? addr_fixed : $urandom;
            plan_grant[c+2+d] = 1'b1; plan_addr[c+2+d] = a;
            e_state[c+3+d] = 3; e_ack[c+3+d] = w; e_addr[c+3+d] = a;
            next_idle = c + 4 + d;
        end else begin
            for (int j = 0; j < TO; j++) begin
                e_state[c+2+j] = 2; in_wait[c+2+j] = 1'b1;
            end
            e_state[c+2+TO] = 3; e_fail[c+2+TO] = w;
            next_idle = c + 3 + TO;
        end
    endtask

    // One clock cycle: drive inputs, predict, compare, update requesters, advance.
    task automatic step();
        logic [N-1:0] ev_ack, ev_fail;
        if (c >= NCYC - 12) begin
            $display("FAIL cycle_budget: got cycle %0d expected below %0d", c, NCYC - 12);
            $fatal(1, "cycle budget exhausted");
        end
        if (in_reset && c == rel_cycle) begin
            reset_n  = 1'b1;
            in_reset = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            fpu_alloc_req[i]          = act[i];
            fpu_alloc_size[16*i +: 16] = rsz[i];
        end
        if (!in_reset && c == next_idle) schedule();
        mmu_alloc_grant   = plan_grant[c] | (stray_en && !in_wait[c] && ($urandom % 3 == 0));
        mmu_alloc_address = plan_grant[c] ? plan_addr[c] : $urandom;
        #1;
        if (e_valid[c]) begin
            m_from = e_from[c];
            m_size = e_size[c];
        end
        if (e_fail[c] >= 0 && m_fcnt < 65535) m_fcnt++;
        ev_ack  = (e_ack[c]  >= 0) ? (N'(1) << e_ack[c])  : '0;
        ev_fail = (e_fail[c] >= 0) ? (N'(1) << e_fail[c]) : '0;
        check($sformatf("state@%0d", c), 64'(debug_state), 64'(e_state[c]));
        check($sformatf("ack@%0d", c), 64'(fpu_alloc_ack), 64'(ev_ack));
        check($sformatf("fail@%0d", c), 64'(fpu_alloc_fail), 64'(ev_fail));
        check($sformatf("addr@%0d", c), 64'(fpu_alloc_addr), 64'(e_addr[c]));
        check($sformatf("valid@%0d", c), 64'(mmu_alloc_request_valid), 64'(e_valid[c]));
        check($sformatf("from@%0d", c), 64'(mmu_alloc_request_from), 64'(m_from));
        check($sformatf("size@%0d", c), 64'(mmu_alloc_size), 64'(m_size));
        check($sformatf("fail_count@%0d", c), 64'(debug_fail_count), 64'(m_fcnt));
        for (int i = 0; i < N; i++) begin
            if (fpu_alloc_ack[i]) begin
                seen_ack.push_back(i);
                seen_addr.push_back(fpu_alloc_addr);
            end
            if (fpu_alloc_fail[i]) seen_fail.push_back(i);
        end
        for (int i = 0; i < N; i++) begin
            if (e_ack[c] == i || e_fail[c] == i) begin
                if (!hold[i] && !(rand_traffic && $urandom % 4 == 0)) act[i] = 1'b0;
                else if (rand_traffic) rsz[i] = rand_size();
            end else if (rand_traffic) begin
                if (!act[i]) begin
                    if ($urandom % 10 == 0) begin
                        act[i] = 1'b1;
                        rsz[i] = rand_size();
                    end
                end else if (i == owner && $urandom % 8 == 0) begin
                    act[i] = 1'b0;
                end else if ($urandom % 16 == 0) begin
                    rsz[i] = rand_size();
                end
            end
        end
        if (e_ack[c] >= 0 || e_fail[c] >= 0) owner = -1;
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) begin
            act[i]  = 1'b0;
            hold[i] = 1'b0;
        end
        rand_traffic = 1'b0;
        run(12);
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        #1;
        check("rst_ack", 64'(fpu_alloc_ack), 64'(0));
        check("rst_fail", 64'(fpu_alloc_fail), 64'(0));
        check("rst_addr", 64'(fpu_alloc_addr), 64'(0));
        check("rst_valid", 64'(mmu_alloc_request_valid), 64'(0));
        check("rst_from", 64'(mmu_alloc_request_from), 64'(0));
        check("rst_size", 64'(mmu_alloc_size), 64'(0));
        check("rst_state", 64'(debug_state), 64'(0));
        check("rst_fail_count", 64'(debug_fail_count), 64'(0));
        clear_from(c);
        m_from = 0; m_size = '0; m_fcnt = 0; last = N - 1; owner = -1;
        in_reset  = 1'b1;
        rel_cycle = c + 2;
        next_idle = c + 2;
    endtask

    initial begin
        clear_from(0);
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; hold[i] = 1'b0; rsz[i] = '0;
        end
        reset_n = 1'b0;
        fpu_alloc_req = '0; fpu_alloc_size = '0;
        mmu_alloc_address = '0; mmu_alloc_grant = 1'b0;
        rand_traffic = 1'b0; stray_en = 1'b0; addr_fixed_en = 1'b0; addr_fixed = '0;
        mmu_mode = 0;
        c = 0; in_reset = 1'b1; rel_cycle = 2; next_idle = 2;
        last = N - 1; owner = -1; m_from = 0; m_size = '0; m_fcnt = 0;
        @(posedge clk);
        #1;
        run(4);

        // T2: three requesters held high, MMU always grants.
        clear_seen();
        act[0] = 1'b1; rsz[0] = 16'd32;
        act[5] = 1'b1; rsz[5] = 16'd48;
        act[9] = 1'b1; rsz[9] = 16'd64;
        hold[0] = 1'b1; hold[5] = 1'b1; hold[9] = 1'b1;
        run(20);
        check("t2_order0", 64'(ack_at(0)), 64'(0));
        check("t2_order1", 64'(ack_at(1)), 64'(5));
        check("t2_order2", 64'(ack_at(2)), 64'(9));
        check("t2_order3", 64'(ack_at(3)), 64'(0));
        drain();

        // T1: single request, known grant address.
        clear_seen();
        addr_fixed_en = 1'b1; addr_fixed = 32'h1000_0300;
        act[3] = 1'b1; rsz[3] = 16'd100;
        run(8);
        check("t1_winner", 64'(ack_at(0)), 64'(3));
        check("t1_addr", 64'(seen_addr.size() > 0 ? seen_addr[0] : 32'hFFFF_FFFF), 64'(32'h1000_0300));
        drain();
        addr_fixed_en = 1'b0;

        // T3: MMU never grants -> timeout fail.
        clear_seen();
        mmu_mode = 1;
        act[7] = 1'b1; rsz[7] = 16'd512;
        run(10);
        check("t3_fail_id", 64'(fail_at(0)), 64'(7));
        check("t3_no_ack", 64'(seen_ack.size()), 64'(0));
        check("t3_fail_count", 64'(debug_fail_count), 64'(1));
        drain();

        // T4: zero-size request is failed without touching the MMU.
        clear_seen();
        mmu_mode = 0;
        act[2] = 1'b1; rsz[2] = 16'd0;
        run(5);
        check("t4_fail_id", 64'(fail_at(0)), 64'(2));
        check("t4_fail_count", 64'(debug_fail_count), 64'(2));
        drain();

        // T5: reset while waiting for a grant, then FPU0 beats FPU15.
        clear_seen();
        mmu_mode = 1;
        act[7] = 1'b1; rsz[7] = 16'd5;
        for (int k = 0; k < 20 && e_state[c] != 2; k++) step();
        check("t5_in_wait", 64'(debug_state), 64'(2));
        reset_now();
        act[7] = 1'b0;
        act[0] = 1'b1; rsz[0] = 16'd64;
        act[15] = 1'b1; rsz[15] = 16'd128;
        mmu_mode = 0;
        run(14);
        check("t5_first", 64'(ack_at(0)), 64'(0));
        check("t5_second", 64'(ack_at(1)), 64'(15));
        check("t5_no_fail", 64'(seen_fail.size()), 64'(0));
        drain();

        // T6: two held requesters alternate; stray grants outside WAIT.
        clear_seen();
        stray_en = 1'b1;
        act[1] = 1'b1; rsz[1] = 16'd16; hold[1] = 1'b1;
        act[2] = 1'b1; rsz[2] = 16'd24; hold[2] = 1'b1;
        run(20);
        check("t6_order0", 64'(ack_at(0)), 64'(1));
        check("t6_order1", 64'(ack_at(1)), 64'(2));
        check("t6_order2", 64'(ack_at(2)), 64'(1));
        check("t6_order3", 64'(ack_at(3)), 64'(2));
        drain();

        // Randomized traffic, grant latency and stray grants.
        rand_traffic = 1'b1;
        mmu_mode     = 2;
        run(1500);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
